// File: rtl/maquina_moore_param_if.sv
`default_nettype none
// ============================================================================
// Module      : maquina_moore_param_if
// Description : Signal bundle for the parameterised Moore up/down counter.
//               master  - drives entrada, sentido, carga, valor_carga and
//                         observes saida, estado, fim.
//               slave   - the counter itself; the mirror of master.
// Ports       : none (WIDTH sets the valor_carga / estado width)
// Revision    : 1.0 - initial release
// ============================================================================
interface maquina_moore_param_if #(
  parameter int WIDTH = 2
);
  logic             entrada;
  logic             sentido;
  logic             carga;
  logic [WIDTH-1:0] valor_carga;
  logic             saida;
  logic [WIDTH-1:0] estado;
  logic             fim;

  modport master (
    output entrada,
    output sentido,
    output carga,
    output valor_carga,
    input  saida,
    input  estado,
    input  fim
  );

  modport slave (
    input  entrada,
    input  sentido,
    input  carga,
    input  valor_carga,
    output saida,
    output estado,
    output fim
  );
endinterface
`default_nettype wire

// File: rtl/maquina_moore_param.sv
`default_nettype none
// ============================================================================
// Module      : maquina_moore_param
// Description : Modulo-MODULO up/down Moore counter with synchronous clamped
//               load, level or rising-edge advance, and a registered
//               one-cycle wrap flag.
// Ports       : clk          - clock, all updates on rising edge
//               rst          - asynchronous active-high reset
//               bus.entrada  - advance request (level, or edge when EDGE=1)
//               bus.sentido  - 0 = count up, 1 = count down
//               bus.carga    - load strobe, wins over advance
//               bus.valor_carga - load value, clamped to MODULO-1
//               bus.saida    - estado[0] (OUT_MODE=0) or estado==MODULO-1
//               bus.estado   - registered state
//               bus.fim      - registered pulse on the cycle a wrap lands
// Revision    : 1.0 - initial release
// ============================================================================
module maquina_moore_param #(
  parameter int WIDTH    = 2,
  parameter int MODULO   = 4,
  parameter int EDGE     = 0,
  parameter int OUT_MODE = 0
) (
  input wire                    clk,
  input wire                    rst,
  maquina_moore_param_if.slave  bus
);

  localparam logic [WIDTH-1:0] c_last = WIDTH'(MODULO - 1);
  localparam logic             c_edge = 1'(EDGE != 0);

  logic [WIDTH-1:0] r_estado;
  logic             r_entrada_d;
  logic             r_fim;

  logic [WIDTH-1:0] w_estado_nxt;
  logic             w_fim_nxt;
  logic             w_advance;
  logic             w_illegal;
  logic [WIDTH-1:0] w_carga_val;

  // In level mode the delayed copy is masked out, so advance == entrada.
  assign w_advance   = bus.entrada & ~(c_edge & r_entrada_d);

  // Only reachable through upsets or deposits when MODULO < 2**WIDTH.
  assign w_illegal   = (32'(r_estado) >= 32'(MODULO));

  assign w_carga_val = (32'(bus.valor_carga) >= 32'(MODULO)) ? c_last
                                                              : bus.valor_carga;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado    <= '0;
      r_entrada_d <= 1'b0;
      r_fim       <= 1'b0;
    end else begin
      r_estado    <= w_estado_nxt;
      r_entrada_d <= bus.entrada;
      r_fim       <= w_fim_nxt;
    end
  end

  // fim is raised only on a genuine step across the wrap boundary; loads
  // and illegal-state recovery land silently.
  always_comb begin
    w_estado_nxt = r_estado;
    w_fim_nxt    = 1'b0;
    if (bus.carga) begin
      w_estado_nxt = w_carga_val;
    end else if (w_illegal) begin
      w_estado_nxt = '0;
    end else if (w_advance) begin
      if (!bus.sentido) begin
        if (r_estado == c_last) begin
          w_estado_nxt = '0;
          w_fim_nxt    = 1'b1;
        end else begin
          w_estado_nxt = r_estado + WIDTH'(1);
        end
      end else begin
        if (r_estado == '0) begin
          w_estado_nxt = c_last;
          w_fim_nxt    = 1'b1;
        end else begin
          w_estado_nxt = r_estado - WIDTH'(1);
        end
      end
    end
  end

  assign bus.estado = r_estado;
  assign bus.fim    = r_fim;

  generate
    if (OUT_MODE != 0) begin : g_out_terminal
      assign bus.saida = (r_estado == c_last);
    end else begin : g_out_parity
      assign bus.saida = r_estado[0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_maquina_moore_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_maquina_moore_param
// Description : Directed bench for maquina_moore_param. Three instances:
//               u0 defaults (W2,M4,level,parity), u1 (W3,M5,level,terminal),
//               u2 (W2,M4,edge,parity).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maquina_moore_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  maquina_moore_param_if #(.WIDTH(2)) if0 ();
  maquina_moore_param_if #(.WIDTH(3)) if1 ();
  maquina_moore_param_if #(.WIDTH(2)) if2 ();

  maquina_moore_param #(.WIDTH(2), .MODULO(4), .EDGE(0), .OUT_MODE(0)) u0 (
    .clk(clk), .rst(rst), .bus(if0));
  maquina_moore_param #(.WIDTH(3), .MODULO(5), .EDGE(0), .OUT_MODE(1)) u1 (
    .clk(clk), .rst(rst), .bus(if1));
  maquina_moore_param #(.WIDTH(2), .MODULO(4), .EDGE(1), .OUT_MODE(0)) u2 (
    .clk(clk), .rst(rst), .bus(if2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if0.entrada = 1'b0; if0.sentido = 1'b0; if0.carga = 1'b0; if0.valor_carga = '0;
    if1.entrada = 1'b0; if1.sentido = 1'b0; if1.carga = 1'b0; if1.valor_carga = '0;
    if2.entrada = 1'b0; if2.sentido = 1'b0; if2.carga = 1'b0; if2.valor_carga = '0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({if0.estado, if0.saida, if0.fim} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async_u0: got estado=%0d saida=%0b fim=%0b want 0 0 0",
               if0.estado, if0.saida, if0.fim);
    end
    checks++;
    if ({if1.estado, if1.saida, if1.fim} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_async_u1: got estado=%0d saida=%0b fim=%0b want 0 0 0",
               if1.estado, if1.saida, if1.fim);
    end
    // inputs must be ignored while reset is held
    if0.entrada = 1'b1; if0.carga = 1'b1; if0.valor_carga = 2'd2;
    if1.entrada = 1'b1; if1.carga = 1'b1; if1.valor_carga = 3'd3;
    if2.entrada = 1'b1;
    tick();
    tick();
    checks++;
    if (if0.estado !== 2'd0 || if1.estado !== 3'd0 || if2.estado !== 2'd0 ||
        if0.fim !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got u0=%0d u1=%0d u2=%0d fim=%0b want 0 0 0 0",
               if0.estado, if1.estado, if2.estado, if0.fim);
    end
    clear_inputs();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_level_up();
    logic [1:0] exp_e [5];
    logic       exp_s [5];
    logic       exp_f [5];
    exp_e = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_s = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_f = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    if0.entrada = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (if0.estado !== exp_e[i] || if0.saida !== exp_s[i] || if0.fim !== exp_f[i]) begin
        errors++;
        $display("FAIL level_up[%0d]: got estado=%0d saida=%0b fim=%0b want %0d %0b %0b",
                 i, if0.estado, if0.saida, if0.fim, exp_e[i], exp_s[i], exp_f[i]);
      end
    end
    if0.entrada = 1'b0;
    tick();
    checks++;
    if (if0.estado !== 2'd1 || if0.fim !== 1'b0) begin
      errors++;
      $display("FAIL level_hold: got estado=%0d fim=%0b want 1 0", if0.estado, if0.fim);
    end
  endtask

  task automatic test_down_wrap();
    if1.sentido = 1'b1;
    if1.entrada = 1'b1;
    tick();
    checks++;
    if (if1.estado !== 3'd4 || if1.fim !== 1'b1 || if1.saida !== 1'b1) begin
      errors++;
      $display("FAIL down_wrap: got estado=%0d fim=%0b saida=%0b want 4 1 1",
               if1.estado, if1.fim, if1.saida);
    end
    tick();
    checks++;
    if (if1.estado !== 3'd3 || if1.fim !== 1'b0 || if1.saida !== 1'b0) begin
      errors++;
      $display("FAIL down_step: got estado=%0d fim=%0b saida=%0b want 3 0 0",
               if1.estado, if1.fim, if1.saida);
    end
    if1.entrada = 1'b0;
    if1.sentido = 1'b0;
  endtask

  task automatic test_edge();
    if2.entrada = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (if2.estado !== 2'd1 || if2.fim !== 1'b0) begin
        errors++;
        $display("FAIL edge_once[%0d]: got estado=%0d fim=%0b want 1 0",
                 i, if2.estado, if2.fim);
      end
    end
    if2.entrada = 1'b0;
    tick();
    if2.entrada = 1'b1;
    tick();
    checks++;
    if (if2.estado !== 2'd2) begin
      errors++;
      $display("FAIL edge_second: got estado=%0d want 2", if2.estado);
    end
    if2.entrada = 1'b0;
    tick();
  endtask

  task automatic test_load_clamp();
    if1.carga = 1'b1;
    if1.valor_carga = 3'd7;
    if1.entrada = 1'b1;
    tick();
    checks++;
    if (if1.estado !== 3'd4 || if1.fim !== 1'b0 || if1.saida !== 1'b1) begin
      errors++;
      $display("FAIL load_clamp: got estado=%0d fim=%0b saida=%0b want 4 0 1",
               if1.estado, if1.fim, if1.saida);
    end
    if1.valor_carga = 3'd0;
    tick();
    checks++;
    if (if1.estado !== 3'd0 || if1.fim !== 1'b0) begin
      errors++;
      $display("FAIL load_zero: got estado=%0d fim=%0b want 0 0", if1.estado, if1.fim);
    end
    if1.valor_carga = 3'd2;
    if1.sentido = 1'b1;
    tick();
    checks++;
    if (if1.estado !== 3'd2 || if1.saida !== 1'b0) begin
      errors++;
      $display("FAIL load_legal: got estado=%0d saida=%0b want 2 0", if1.estado, if1.saida);
    end
    if1.carga = 1'b0;
    if1.entrada = 1'b0;
    if1.sentido = 1'b0;
  endtask

  task automatic test_async_reset();
    if0.carga = 1'b1;
    if0.valor_carga = 2'd3;
    tick();
    checks++;
    if (if0.estado !== 2'd3 || if0.fim !== 1'b0) begin
      errors++;
      $display("FAIL load_three: got estado=%0d fim=%0b want 3 0", if0.estado, if0.fim);
    end
    if0.carga = 1'b0;
    if0.entrada = 1'b1;
    #3 rst = 1'b1;
    #1;
    checks++;
    if (if0.estado !== 2'd0 || if0.saida !== 1'b0 || if0.fim !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_cycle: got estado=%0d saida=%0b fim=%0b want 0 0 0",
               if0.estado, if0.saida, if0.fim);
    end
    if2.entrada = 1'b1;
    tick();
    checks++;
    if (if0.estado !== 2'd0 || if2.estado !== 2'd0) begin
      errors++;
      $display("FAIL rst_held: got u0=%0d u2=%0d want 0 0", if0.estado, if2.estado);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (if0.estado !== 2'd1 || if2.estado !== 2'd1) begin
      errors++;
      $display("FAIL rst_resume: got u0=%0d u2=%0d want 1 1", if0.estado, if2.estado);
    end
    tick();
    tick();
    tick();
    checks++;
    if (if0.estado !== 2'd0 || if0.fim !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_wrap: got estado=%0d fim=%0b want 0 1", if0.estado, if0.fim);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (if0.fim !== 1'b0 || if0.estado !== 2'd0) begin
      errors++;
      $display("FAIL rst_kills_fim: got estado=%0d fim=%0b want 0 0", if0.estado, if0.fim);
    end
    if0.entrada = 1'b0;
    if2.entrada = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    if1.carga = 1'b1;
    if1.valor_carga = 3'd2;
    tick();
    if1.carga = 1'b0;
    force u1.r_estado = 3'd6;
    #1;
    checks++;
    if (if1.estado !== 3'd6) begin
      errors++;
      $display("FAIL illegal_deposit: got estado=%0d want 6", if1.estado);
    end
    release u1.r_estado;
    if1.entrada = 1'b1;
    tick();
    checks++;
    if (if1.estado !== 3'd0 || if1.fim !== 1'b0) begin
      errors++;
      $display("FAIL illegal_recover: got estado=%0d fim=%0b want 0 0", if1.estado, if1.fim);
    end
    tick();
    checks++;
    if (if1.estado !== 3'd1) begin
      errors++;
      $display("FAIL illegal_after: got estado=%0d want 1", if1.estado);
    end
    if1.entrada = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_level_up();
    test_down_wrap();
    test_edge();
    test_load_clamp();
    test_async_reset();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/maquina_moore_param.md
MAQUINA_MOORE_PARAM -- requirements
Module: maquina_moore_param

Interface
REQ-001 SHALL have parameter WIDTH, default 2, state register width in bits (1..16).
REQ-002 SHALL have parameter MODULO, default 4, number of states (2..2**WIDTH).
REQ-003 SHALL have parameter EDGE, default 0, advance trigger: 0 = level on entrada, 1 = rising edge of entrada.
REQ-004 SHALL have parameter OUT_MODE, default 0, saida source: 0 = estado[0] (parity), 1 = terminal state (estado == MODULO-1).
REQ-005 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port entrada  input  1  advance request (level or edge per EDGE).
REQ-008 SHALL have port sentido  input  1  direction: 0 = up, 1 = down.
REQ-009 SHALL have port carga  input  1  synchronous load strobe.
REQ-010 SHALL have port valor_carga  input  WIDTH  load value.
REQ-011 SHALL have port saida  output  1  Moore output per OUT_MODE.
REQ-012 SHALL have port estado  output  WIDTH  current state, registered.
REQ-013 SHALL have port fim  output  1  one-cycle wrap indication, registered.

Function
REQ-014 SHALL be a Moore machine: saida and fim depend only on registered values, never combinationally on inputs.
REQ-015 SHALL compute advance = entrada when EDGE=0; advance = entrada AND NOT entrada_d when EDGE=1, entrada_d being entrada registered one cycle.
REQ-016 SHALL give carga priority over advance: when carga=1, next estado = valor_carga, regardless of entrada/sentido.
REQ-017 SHALL clamp loads: valor_carga >= MODULO loads MODULO-1.
REQ-018 SHALL, when carga=0 and advance=1 and sentido=0, set next estado = estado+1, wrapping MODULO-1 -> 0.
REQ-019 SHALL, when carga=0 and advance=1 and sentido=1, set next estado = estado-1, wrapping 0 -> MODULO-1.
REQ-020 SHALL hold estado when carga=0 and advance=0 (explicit hold, no latch inferred).
REQ-021 SHALL assert fim for exactly the one cycle in which estado first shows the post-wrap value; a load never asserts fim, even if it lands on 0 or MODULO-1.
REQ-022 SHALL, for a level advance held N cycles (EDGE=0), step once per cycle, so fim pulses once per wrap.
REQ-023 SHALL, for EDGE=1, step once per rising edge; entrada held high steps exactly once.
REQ-024 SHALL recover to state 0 on the next clock if estado ever holds a value >= MODULO (illegal state), without asserting fim.
REQ-025 SHALL have latency of one clock from sampled carga/advance to updated estado, saida, fim.

Reset
REQ-026 SHALL, on rst=1, immediately and asynchronously set estado=0, entrada_d=0, fim=0, saida=0.
REQ-027 SHALL hold that reset state while rst=1, ignoring all inputs.
REQ-028 SHALL resume operation on the first rising clk edge after rst deasserts; entrada already high at that edge counts as a rising edge when EDGE=1.
REQ-029 SHALL, on reset mid-count or mid-fim pulse, abort immediately; no pending step or fim survives reset.

Verification
REQ-030 Defaults (WIDTH=2, MODULO=4, EDGE=0, OUT_MODE=0), sentido=0, entrada=1 for 5 cycles -> estado 1,2,3,0,1; saida 1,0,1,0,1; fim=1 only with estado=0.
REQ-031 MODULO=5, WIDTH=3, sentido=1 from estado=0, entrada=1 for 2 cycles -> estado 4 (fim=1), then 3 (fim=0).
REQ-032 EDGE=1, entrada held high 4 cycles then low -> estado advances 0->1 once; repeat pulse -> 2.
REQ-033 MODULO=5, WIDTH=3, carga=1, valor_carga=7, entrada=1 same cycle -> estado=4, fim=0; OUT_MODE=1 gives saida=1.
REQ-034 rst pulsed asynchronously between clk edges at estado=3 -> estado, saida, fim read 0 before next edge; count resumes from 0 after release.
REQ-035 Force estado=6 with MODULO=5, WIDTH=3 (bench deposit), no carga -> estado=0 next cycle, fim=0.
